clk_gen_nch: RTL
================

# clk_gen_nch

Multi-channel programmable clock/strobe generator for the LCD driver. It derives CH independent divided clocks from `clk_in`, for example the pixel clock, the backlight PWM base and the scan strobe. Each channel has a glitch-free start and stop, a shadowed divide value, a rising-edge tick output, and a global `sync` that phase-aligns all channels. It sits between the board clock and the LCD timing/controller blocks.

## Interface
Parameters:
- `CH`, default 2: number of channels.
- `W`, default 16: divide counter width.

Ports:
- `clk_in`, in, 1: single system clock; all logic is on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `en`, in, CH: per-channel run request, level.
- `div`, in, CH*W: per-channel half-period minus one. Channel i uses bits `[i*W +: W]`.
- `sync`, in, 1: one-cycle pulse that realigns all running channels.
- `clk_out`, out, CH: divided clocks, registered.
- `tick`, out, CH: one-cycle pulse, asserted in the same cycle that `clk_out[i]` becomes 1.
- `running`, out, CH: 1 while the channel is in RUN or STOP.

## Operation
- Each channel has an independent FSM with states IDLE, RUN and STOP. Each channel holds a W-bit `count` and a W-bit shadow register `div_act`.
- IDLE:
  - `clk_out`=0 and `count`=0.
  - `en`=1 moves to RUN, with `count`<=0 and `div_act`<=`div`.
- RUN, every cycle:
  - If `count`==`div_act`: `count`<=0, `clk_out`<=~`clk_out`, and `div_act`<=`div`. The shadow reloads only at toggles, so a change to `div` mid-phase never shortens or stretches the current phase.
  - Otherwise: `count`<=`count`+1, unsigned, width W.
  - Output period is 2*(`div_act`+1) cycles at 50% duty. `div`=0 gives `clk_in`/2.
- RUN with `en`=0:
  - If `clk_out`=0: go to IDLE, `count`<=0.
  - Otherwise: go to STOP.
- STOP:
  - Counting continues as in RUN.
  - At the terminal count, `clk_out` falls and the channel goes to IDLE. The high phase is never truncated.
  - `en`=1 in STOP returns to RUN with no disturbance to `count` or `clk_out`.
- `tick[i]` <= (state≠IDLE) && (`count`==`div_act`) && (`clk_out`==0).
- `sync`=1: every channel in RUN or STOP is forced to `count`<=0, `clk_out`<=0 and `div_act`<=`div`, with no tick. A channel that was in STOP goes to IDLE. IDLE channels are unaffected.
- Precedence: `rst` > `sync` > terminal-count toggle > `en` transitions.
- `count` never exceeds `div_act`. If a reload writes a smaller value, it applies only from `count`=0.

## Timing
- Reset values: `clk_out`=0, `tick`=0, `running`=0, all channels IDLE, `count`=0, `div_act`=0. Reset is asynchronous on assert and synchronous on release.
- `en` rising at edge t gives `running`=1 after edge t. The first `clk_out`/`tick` rise comes `div`+1 edges later.
- Output latency is purely registered. `clk_out` and `tick` have no combinational path from any input.
- `sync` sampled at edge t gives `clk_out`=0 and `count`=0 after edge t. The next rise comes `div`+1 edges later, identical on all channels that share the same `div`.
- `rst` asserted mid-phase clears all outputs immediately, with no completion of the phase.

## Configuration
- `CLK_GEN_PHASE_EN` defined:
  - Adds input `phase`, CH*W.
  - On RUN entry and on `sync`, `count` loads min(`phase[i]`, `div[i]`) instead of 0. This gives per-channel phase offsets, such as staggered backlight strobes.
- `CLK_GEN_PHASE_EN` undefined: the `phase` port is absent and `count` always initialises to 0.

## Structure
- Package `clk_gen_pkg` holds:
  - The default `W`.
  - The FSM state enum (IDLE/RUN/STOP, 2-bit encoding).
- Sub-module `clk_gen_ch`: one channel (FSM, counter, shadow, tick). The top instantiates it CH times in a generate loop and fans out `sync`.

## Test plan
- Reset then `en[0]`=1 with `div[0]`=3 → `clk_out[0]` period is 8 cycles, high 4 cycles, first rise 4 edges after enable, and `tick` pulses once per period.
- `div`=0 → `clk_out` toggles every cycle, `tick` every 2nd cycle.
- Change `div` from 3 to 1 mid high-phase → the current phase completes at 4 cycles, and subsequent phases are 2 cycles.
- Drop `en` one cycle after a rise with `div`=5 → `clk_out` stays high the full 6 cycles, then stays 0, and `running` falls on the same edge. Re-assert `en` during STOP → the waveform continues unbroken.
- Two channels with `div`=4 and `div`=2, then pulse `sync` → both `clk_out` go to 0 on the next edge, and they rise after 5 and 3 edges respectively, with no tick on the `sync` edge.
- Assert `rst` mid-phase → `clk_out`, `tick` and `running` go to 0 without waiting for a clock edge. With `CLK_GEN_PHASE_EN`, `phase`=2 and `div`=3 → the first rise comes 2 edges after enable.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared defaults and the per-channel FSM encoding for clk_gen_nch.
package clk_gen_pkg;

  localparam int unsigned DefaultW = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStop = 2'd2
  } ch_state_e;

endpackage

// File: rtl/clk_gen_ch.sv
// clk_gen_ch: one divided-clock channel with a shadowed divide value, a glitch-free
// start/stop sequence, a registered rising-edge tick and a sync realignment.
module clk_gen_ch
  import clk_gen_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         sync_i,
  input  logic [W-1:0] div_i,
  input  logic [W-1:0] init_i,
  output logic         clk_o,
  output logic         tick_o,
  output logic         running_o
);

  ch_state_e    state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] div_act_q, div_act_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic         term;

  assign term = (count_q == div_act_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    div_act_d = div_act_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d   = StRun;
          count_d   = init_i;
          div_act_d = div_i;
        end
      end
      StRun, StStop: begin
        if (sync_i) begin
          clk_d     = 1'b0;
          div_act_d = div_i;
          if (state_q == StRun) begin
            count_d = init_i;
          end else begin
            state_d = StIdle;
            count_d = '0;
          end
        end else if (term) begin
          // Toggle wins over en; where the channel lands depends on the new level.
          count_d   = '0;
          clk_d     = ~clk_q;
          div_act_d = div_i;
          tick_d    = ~clk_q;
          if (en_i) begin
            state_d = StRun;
          end else if (clk_q) begin
            state_d = StIdle;
          end else begin
            state_d = StStop;
          end
        end else begin
          count_d = count_q + W'(1);
          if (en_i) begin
            state_d = StRun;
          end else if (!clk_q) begin
            state_d = StIdle;
            count_d = '0;
          end else begin
            state_d = StStop;
          end
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      count_q   <= '0;
      div_act_q <= '0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      div_act_q <= div_act_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_o     = clk_q;
  assign tick_o    = tick_q;
  assign running_o = (state_q != StIdle);

endmodule

// File: rtl/clk_gen_nch.sv
// clk_gen_nch: CH independent programmable divided clocks sharing one sync pulse.
// Defining CLK_GEN_PHASE_EN adds a per-channel start-phase input.
module clk_gen_nch
  import clk_gen_pkg::*;
#(
  parameter int unsigned CH = 2,
  parameter int unsigned W  = DefaultW
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [CH-1:0]   en,
  input  logic [CH*W-1:0] div,
`ifdef CLK_GEN_PHASE_EN
  input  logic [CH*W-1:0] phase,
`endif
  input  logic            sync,
  output logic [CH-1:0]   clk_out,
  output logic [CH-1:0]   tick,
  output logic [CH-1:0]   running
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] div_ch;
    logic [W-1:0] init_ch;

    assign div_ch = div[i*W +: W];

`ifdef CLK_GEN_PHASE_EN
    logic [W-1:0] phase_ch;
    assign phase_ch = phase[i*W +: W];
    // Clamp so the start count never exceeds the shadowed divide value.
    assign init_ch  = (phase_ch < div_ch) ? phase_ch : div_ch;
`else
    assign init_ch = '0;
`endif

    clk_gen_ch #(
      .W(W)
    ) u_ch (
      .clk_i    (clk_in),
      .rst_i    (rst),
      .en_i     (en[i]),
      .sync_i   (sync),
      .div_i    (div_ch),
      .init_i   (init_ch),
      .clk_o    (clk_out[i]),
      .tick_o   (tick[i]),
      .running_o(running[i])
    );
  end

endmodule
